// File: rtl/qif_spike_monitor.sv
// Spike monitor for a QIF neuron stage: measures inter-spike intervals into a
// small FIFO and reports the spike count of each fixed-length rate window.
module qif_spike_monitor #(
  parameter int DEPTH       = 4,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spike_in,
  output logic [7:0] isi_data,
  output logic       isi_valid,
  input  logic       isi_ready,
  output logic [7:0] rate,
  output logic       overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

  logic                   spike_q, spike_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   armed_q, armed_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [7:0]             ev_cnt_q, ev_cnt_d;
  logic [7:0]             rate_q, rate_d;
  logic                   ovf_q, ovf_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         occ_q, occ_d;
  logic [7:0]             mem_q [DEPTH];
  logic [7:0]             mem_d [DEPTH];

  logic       spike_event;
  logic [7:0] cnt_inc;
  logic [7:0] ev_total;
  logic       push;
  logic       pop;
  logic       full;
  logic       do_write;
  logic       drop;

  assign spike_event = ena & spike_in & ~spike_q;
  assign cnt_inc     = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
  assign ev_total    = spike_event ? ((ev_cnt_q == 8'hFF) ? 8'hFF : ev_cnt_q + 8'd1)
                                   : ev_cnt_q;
  assign push        = spike_event & armed_q;
  assign pop         = isi_valid & isi_ready;
  assign full        = (occ_q == FULL_OCC);
  // A push into a full FIFO survives only if the head leaves in the same cycle.
  assign do_write    = push & (~full | pop);
  assign drop        = push & full & ~pop;

  assign isi_valid = (occ_q != '0);
  assign isi_data  = mem_q[rd_ptr_q];
  assign rate      = rate_q;
  assign overflow  = ovf_q;

  always_comb begin
    spike_d  = spike_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    win_d    = win_q;
    ev_cnt_d = ev_cnt_q;
    rate_d   = rate_q;
    ovf_d    = ovf_q | drop;
    if (ena) begin
      spike_d = spike_in;
      win_d   = win_q + WINDOW_LOG2'(1);
      if (spike_event) begin
        cnt_d   = 8'd0;
        armed_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
      if (&win_q) begin
        rate_d   = ev_total;
        ev_cnt_d = 8'd0;
      end else begin
        ev_cnt_d = ev_total;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_write) begin
      mem_d[wr_ptr_q] = cnt_inc;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_write, pop})
      2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q  <= 1'b0;
      cnt_q    <= 8'd0;
      armed_q  <= 1'b0;
      win_q    <= '0;
      ev_cnt_q <= 8'd0;
      rate_q   <= 8'd0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      spike_q  <= spike_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      win_q    <= win_d;
      ev_cnt_q <= ev_cnt_d;
      rate_q   <= rate_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_qif_spike_monitor.sv
// Randomized and directed bench for qif_spike_monitor, checked by a
// scoreboard fed from an event-time reference model.
module tb_qif_spike_monitor;

  localparam int DEPTH       = 4;
  localparam int WINDOW_LOG2 = 8;
  localparam int WIN         = 1 << WINDOW_LOG2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike_in = 1'b0;
  logic       isi_ready = 1'b0;
  logic [7:0] isi_data;
  logic       isi_valid;
  logic [7:0] rate;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  qif_spike_monitor #(.DEPTH(DEPTH), .WINDOW_LOG2(WINDOW_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .isi_data  (isi_data),
    .isi_valid (isi_valid),
    .isi_ready (isi_ready),
    .rate      (rate),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: times are counted in enabled cycles since reset.
  int      sb[$];
  bit      popped = 0;
  bit      m_prev = 0;
  bit      m_armed = 0;
  bit      m_ovf = 0;
  int      m_rate = 0;
  int      win_events = 0;
  longint  en_idx = 0;
  longint  last_ev = 0;
  longint  isi;
  int      occ_before;
  bit      popped_now;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    sb.delete();
    popped     = 0;
    m_prev     = 0;
    m_armed    = 0;
    m_ovf      = 0;
    m_rate     = 0;
    win_events = 0;
    en_idx     = 0;
    last_ev    = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      popped_now = popped;
      occ_before = sb.size() + (popped ? 1 : 0);
      popped     = 0;
      if (ena) begin
        if (spike_in && !m_prev) begin
          if (m_armed) begin
            isi = en_idx - last_ev;
            if (isi > 255) isi = 255;
            if (occ_before < DEPTH || popped_now) sb.push_back(int'(isi));
            else m_ovf = 1;
          end
          m_armed = 1;
          last_ev = en_idx;
          win_events++;
        end
        m_prev = spike_in;
        if ((en_idx % WIN) == WIN - 1) begin
          m_rate     = (win_events > 255) ? 255 : win_events;
          win_events = 0;
        end
        en_idx++;
      end
    end
  end

  // Monitor: compares presented outputs and retires scoreboard entries.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("isi_valid_in_reset", int'(isi_valid), 0);
    end else begin
      check_output("isi_valid", int'(isi_valid), (sb.size() != 0) ? 1 : 0);
      check_output("overflow", int'(overflow), int'(m_ovf));
      check_output("rate", int'(rate), m_rate);
      if (sb.size() != 0) begin
        check_output("isi_data", int'(isi_data), sb[0]);
        if (isi_ready) begin
          void'(sb.pop_front());
          popped = 1;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic en, input logic sp, input logic rdy);
    ena       = en;
    spike_in  = sp;
    isi_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    ena      = 1'b0;
    spike_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_isi_valid", int'(isi_valid), 0);
    check_output("reset_rate", int'(rate), 0);
    check_output("reset_overflow", int'(overflow), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_output("init_isi_valid", int'(isi_valid), 0);
    check_output("init_rate", int'(rate), 0);
    check_output("init_overflow", int'(overflow), 0);
    rst_n = 1'b1;

    $display("[TB] pulses at 10, 20, 45");
    for (int c = 0; c < 60; c++) apply_stimulus(1'b1, (c == 10 || c == 20 || c == 45), 1'b1);

    $display("[TB] overflow with consumer stalled");
    pulse_reset();
    for (int c = 0; c < 22; c++) apply_stimulus(1'b1, (c % 3 == 0) && (c <= 15), 1'b0);
    for (int c = 0; c < 10; c++) apply_stimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] interval saturation");
    pulse_reset();
    for (int c = 0; c < 310; c++) apply_stimulus(1'b1, (c == 0 || c == 300), 1'b1);

    $display("[TB] held-high spike input");
    pulse_reset();
    for (int c = 0; c < 300; c++) apply_stimulus(1'b1, c < 50, 1'b1);

    $display("[TB] periodic spikes with enable gap");
    pulse_reset();
    k = 0;
    for (int c = 0; c < 560; c++) begin
      if (c >= 100 && c < 120) apply_stimulus(1'b0, 1'b0, 1'b1);
      else begin
        apply_stimulus(1'b1, (k % 4) == 0, 1'b1);
        k++;
      end
    end

    $display("[TB] full FIFO with simultaneous pop and push");
    pulse_reset();
    for (int c = 0; c < 30; c++) apply_stimulus(1'b1, (c % 3 == 0), c >= 15);
    for (int c = 0; c < 260; c++) apply_stimulus(1'b1, (c % 4 == 0), 1'b1);
    for (int c = 0; c < 20; c++) apply_stimulus(1'b1, (c % 3 == 0), 1'b0);
    pulse_reset();
    for (int c = 0; c < 20; c++) apply_stimulus(1'b1, (c % 5 == 0), 1'b1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 9) != 0, ($urandom_range(0, 4) == 0),
                     $urandom_range(0, 1) == 1);
      if (c == 1500) pulse_reset();
    end
    for (int c = 0; c < 10; c++) apply_stimulus(1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qif_spike_monitor.md
QIF_SPIKE_MONITOR -- requirements
Module: qif_spike_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of ISI FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WINDOW_LOG2, default 8, meaning the rate window is 2^WINDOW_LOG2 enabled cycles.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  advance enable; when low, spike sampling, ISI and window counters freeze.
REQ-006 SHALL have port spike_in  input  1  spike pulse from the upstream QIF neuron stage.
REQ-007 SHALL have port isi_data  output  8  inter-spike interval at the FIFO head, unsigned cycles.
REQ-008 SHALL have port isi_valid  output  1  high when the FIFO is non-empty.
REQ-009 SHALL have port isi_ready  input  1  consumer accepts isi_data on a cycle with isi_valid and isi_ready both high.
REQ-010 SHALL have port rate  output  8  spike count from the last completed window, unsigned.
REQ-011 SHALL have port overflow  output  1  sticky flag: an ISI sample was dropped.

Function
REQ-012 SHALL register spike_in into spike_d on every enabled cycle; event = ena & spike_in & ~spike_d (rising edge only; held-high input counts once).
REQ-013 SHALL keep an 8-bit ISI counter cnt and an armed flag, both 0 after reset.
REQ-014 On an enabled cycle with no event, SHALL set cnt <= min(cnt+1, 255).
REQ-015 On an event, SHALL set cnt <= 0, set armed <= 1, and, only if armed was already 1, push min(cnt+1, 255) into the FIFO; events k enabled cycles apart therefore yield ISI = k, saturating at 255.
REQ-016 The first event after reset SHALL arm only and push nothing.
REQ-017 FIFO SHALL be first-in first-out, DEPTH entries, no combinational bypass: a value pushed in cycle N is first visible on isi_data/isi_valid in cycle N+1.
REQ-018 Pop SHALL occur when isi_valid & isi_ready; pop operates regardless of ena.
REQ-019 Push while full with no pop in the same cycle SHALL drop the new sample, leave FIFO contents unchanged, and set overflow <= 1.
REQ-020 Push and pop in the same cycle while full SHALL both take effect (no drop, occupancy unchanged); while empty, only the push takes effect.
REQ-021 isi_data SHALL equal the head entry while isi_valid is high; its value while isi_valid is low is don't-care.
REQ-022 SHALL keep a WINDOW_LOG2-bit window counter incrementing on every enabled cycle, wrapping from all-ones to 0.
REQ-023 SHALL keep an 8-bit saturating event counter incremented per event.
REQ-024 On the enabled cycle where the window counter is all-ones, SHALL load rate <= event count including that cycle's event (saturated at 255), and clear the event counter to 0.
REQ-025 overflow SHALL remain 1 until reset.

Reset
REQ-026 Asserting rst_n low SHALL immediately, without clk, clear spike_d, cnt, armed, window counter, event counter, FIFO pointers/occupancy, rate and overflow to 0; isi_valid goes 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued ISIs; after release the first event only re-arms.
REQ-028 After rst_n deasserts, the first state update SHALL occur on the next rising clk.

Verification
REQ-029 Reset, ena=1, isi_ready=1, spike_in pulses (1 cycle) at cycles 10, 20, 45 -> no push at 10; isi_data=10 then 25, each valid for one cycle, cycle after the spike.
REQ-030 isi_ready=0, five spikes 3 cycles apart after arming -> four entries of 3 queued, fifth dropped, overflow=1; then isi_ready=1 drains exactly four 3s.
REQ-031 Spikes 300 cycles apart -> isi_data=255 (saturation).
REQ-032 spike_in held high 50 cycles -> exactly one event; rate for that window = 1.
REQ-033 spike pulse every 4 enabled cycles for one full 256-cycle window -> rate=64 on wrap; ena low for 20 cycles mid-run -> counters frozen, ISI unaffected by the gap.
REQ-034 FIFO full, isi_ready=1 coinciding with a push -> no drop, overflow stays 0; rst_n pulsed low mid-queue -> isi_valid=0 immediately, rate=0.
